// File: rtl/kbd_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, modifier tracking, ASCII mapping and key-event FIFO.
// Optional: define KBD_TYPEMATIC_FILTER_EN to suppress repeated makes of the same held key.
module kbd_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] code,
    input  logic       code_valid,
    input  logic       rd_en,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    output logic [4:0] fifo_count,
    output logic       shift_on,
    output logic       caps_on,
    output logic       ctrl_on,
    output logic       overflow,
    output logic [7:0] make_count
);
    localparam int         AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

    state_t      state_q, state_d;
    logic        shift_q, shift_d, caps_q, caps_d, ctrl_q, ctrl_d;
    logic [7:0]  mk_cnt_q, mk_cnt_d;
    logic        ovf_q, ovf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        push, do_push, pop, full, is_mod;
    logic [7:0]  push_data;
`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [7:0]  last_q, last_d;
    logic        last_vld_q, last_vld_d;
`endif

    function automatic logic [7:0] map_code(input logic [7:0] c, input logic upper,
                                            input logic shifted);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        if (upper && a >= 8'h61 && a <= 8'h7A) begin
            a = a - 8'h20;
        end else if (shifted && a >= 8'h30 && a <= 8'h39) begin
            case (a)
                8'h30: a = 8'h29; 8'h31: a = 8'h21; 8'h32: a = 8'h40; 8'h33: a = 8'h23;
                8'h34: a = 8'h24; 8'h35: a = 8'h25; 8'h36: a = 8'h5E; 8'h37: a = 8'h26;
                8'h38: a = 8'h2A; default: a = 8'h28;
            endcase
        end
        return a;
    endfunction

    assign is_mod    = (code == 8'h12) || (code == 8'h59) || (code == 8'h14) || (code == 8'h58);
    // Mapping uses the modifier state from before this code.
    assign push_data = map_code(code, shift_q ^ caps_q, shift_q);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        caps_d   = caps_q;
        ctrl_d   = ctrl_q;
        mk_cnt_d = mk_cnt_q;
        push     = 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        if (code_valid) begin
            state_d = IDLE;
            case (state_q)
                IDLE: begin
                    if (code == 8'hF0) begin
                        state_d = BRK;
                    end else if (code == 8'hE0) begin
                        state_d = EXT;
                    end else if (is_mod) begin
                        mk_cnt_d = mk_cnt_q + 8'd1;
                        if (code == 8'h12 || code == 8'h59) shift_d = 1'b1;
                        if (code == 8'h14)                  ctrl_d  = 1'b1;
                        if (code == 8'h58)                  caps_d  = ~caps_q;
                    end else begin
`ifdef KBD_TYPEMATIC_FILTER_EN
                        if (!(last_vld_q && code == last_q)) begin
                            last_d     = code;
                            last_vld_d = 1'b1;
                            mk_cnt_d   = mk_cnt_q + 8'd1;
                            push       = (push_data != 8'h00);
                        end
`else
                        mk_cnt_d = mk_cnt_q + 8'd1;
                        push     = (push_data != 8'h00);
`endif
                    end
                end
                BRK: begin
                    if (code == 8'h12 || code == 8'h59) shift_d = 1'b0;
                    if (code == 8'h14)                  ctrl_d  = 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
                    if (code == last_q) last_vld_d = 1'b0;
`endif
                end
                EXT: begin
                    if (code == 8'hF0)      state_d = EXTBRK;
                    else if (code == 8'h14) ctrl_d  = 1'b1;
                end
                default: begin
                    if (code == 8'h14) ctrl_d = 1'b0;
                end
            endcase
        end
    end

    assign pop     = rd_en && (cnt_q != 5'd0);
    assign full    = (cnt_q == DEPTH);
    assign do_push = push && (!full || pop);
    assign ovf_d   = ovf_q | (push && full && !pop);
    assign cnt_d   = cnt_q + 5'(do_push) - 5'(pop);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q  <= IDLE;
            shift_q  <= 1'b0;
            caps_q   <= 1'b0;
            ctrl_q   <= 1'b0;
            mk_cnt_q <= 8'd0;
            ovf_q    <= 1'b0;
            cnt_q    <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef KBD_TYPEMATIC_FILTER_EN
            last_q     <= 8'd0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            caps_q   <= caps_d;
            ctrl_q   <= ctrl_d;
            mk_cnt_q <= mk_cnt_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef KBD_TYPEMATIC_FILTER_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    // Storage needs no reset: the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign key_valid  = (cnt_q != 5'd0);
    assign key_ascii  = key_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = cnt_q;
    assign shift_on   = shift_q;
    assign caps_on    = caps_q;
    assign ctrl_on    = ctrl_q;
    assign overflow   = ovf_q;
    assign make_count = mk_cnt_q;
endmodule
